// File: rtl/add_round_key_expkey.sv
// AES-128 AddRoundKey stage with an iterative, in-place key expansion.
// Round keys 0..10 are derived on the fly from the loaded cipher key, one
// 32-bit column word per cycle. Each accepted state is XORed with the current
// round key and handed downstream with a valid pulse and the round index.
// Block byte order is row-major: byte n = bits [8n:8n+7], n = 4*row + col.
module add_round_key_expkey #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         keyLoad,
  input  logic [0:127] chave,
  input  logic         inValid,
  output logic         inReady,
  input  logic [0:127] blocoIn,
  output logic [0:127] blocoOut,
  output logic         outValid,
  output logic [3:0]   roundOut
);

  // Only the AES-128 schedule (ten expansion rounds) is implemented.
  if (NUM_ROUNDS != 10) begin : g_cfg_error
    $error("add_round_key_expkey: NUM_ROUNDS must be 10 (AES-128)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // FIPS-197 forward S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_NOKEY  = 2'd0,
    S_READY  = 2'd1,
    S_EXPAND = 2'd2,
    S_WRAP   = 2'd3
  } state_e;

  // Byte substitution through the local S-box.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // SubWord: S-box applied to each byte of a column word.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant byte for rounds 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Column c of a row-major block as a word, row 0 in the top byte.
  function automatic logic [31:0] col_of(input logic [0:127] blk, input int c);
    return {blk[8*c +: 8], blk[8*(4+c) +: 8], blk[8*(8+c) +: 8], blk[8*(12+c) +: 8]};
  endfunction

  state_e       r_state;
  state_e       w_state_nxt;
  logic [31:0]  r_w [0:3];      // current round key, one word per column
  logic [0:127] r_master;       // cipher key, restored on wrap
  logic [3:0]   r_round;        // index of the round key held in r_w
  logic [1:0]   r_k;            // word being expanded
  logic [0:127] r_bloco_out;
  logic         r_out_valid;
  logic [3:0]   r_round_out;

  logic         w_accept;
  logic [0:127] w_key_blk;
  logic [31:0]  w_temp;
  logic [31:0]  w_new_word;

  assign inReady  = (r_state == S_READY);
  assign w_accept = inValid && inReady && !keyLoad;

  assign blocoOut = r_bloco_out;
  assign outValid = r_out_valid;
  assign roundOut = r_round_out;

  // Reassemble the column words into a row-major block for the XOR.
  // NOTE: every combinational output gets a default before any branch or loop,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_key_blk = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_key_blk[8*(4*r+c) +: 8] = r_w[c][8*(3-r) +: 8];
      end
    end
  end

  // One expansion step: word 0 mixes in SubWord(RotWord(w3)) and Rcon,
  // words 1..3 chain off the freshly updated previous word.
  always_comb begin
    w_temp = r_w[r_k - 2'd1];
    if (r_k == 2'd0) begin
      w_temp = sub_word({r_w[3][23:0], r_w[3][31:24]}) ^ {rcon(r_round + 4'd1), 24'h0};
    end
    w_new_word = r_w[r_k] ^ w_temp;
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_NOKEY;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a key load pre-empts whatever the block was doing.
  always_comb begin
    w_state_nxt = r_state;
    if (keyLoad) begin
      w_state_nxt = S_READY;
    end else begin
      case (r_state)
        S_NOKEY:  w_state_nxt = S_NOKEY;
        S_READY:  if (w_accept) w_state_nxt = (r_round < LAST_ROUND) ? S_EXPAND : S_WRAP;
        S_EXPAND: if (r_k == 2'd3) w_state_nxt = S_READY;
        S_WRAP:   w_state_nxt = S_READY;
        default:  w_state_nxt = S_NOKEY;
      endcase
    end
  end

  // Key store, expansion counters and the registered output stage.
  // NOTE: the key store is a small register array, not a RAM, so clearing it
  // in reset is cheap and keeps a stale key from surviving a reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < 4; c++) r_w[c] <= '0;
      r_master    <= '0;
      r_round     <= '0;
      r_k         <= '0;
      r_bloco_out <= '0;
      r_out_valid <= 1'b0;
      r_round_out <= '0;
    end else begin
      r_out_valid <= w_accept;
      if (keyLoad) begin
        for (int c = 0; c < 4; c++) r_w[c] <= col_of(chave, c);
        r_master <= chave;
        r_round  <= '0;
        r_k      <= '0;
      end else if (w_accept) begin
        r_bloco_out <= blocoIn ^ w_key_blk;
        r_round_out <= r_round;
        r_k         <= '0;
      end else if (r_state == S_EXPAND) begin
        r_w[r_k] <= w_new_word;
        r_k      <= r_k + 2'd1;
        if (r_k == 2'd3) r_round <= r_round + 4'd1;
      end else if (r_state == S_WRAP) begin
        for (int c = 0; c < 4; c++) r_w[c] <= col_of(r_master, c);
        r_round <= '0;
      end
    end
  end

endmodule

// File: tb/tb_add_round_key_expkey.sv
// Self-checking bench for add_round_key_expkey. The reference model derives
// the S-box from GF(2^8) inversion plus the affine map, expands keys with the
// FIPS-197 word recurrence, and tracks availability as a busy-cycle count.
module tb_add_round_key_expkey;

  logic         clock = 1'b0;
  logic         reset;
  logic         keyLoad;
  logic [0:127] chave;
  logic         inValid;
  logic         inReady;
  logic [0:127] blocoIn;
  logic [0:127] blocoOut;
  logic         outValid;
  logic [3:0]   roundOut;

  add_round_key_expkey #(.NUM_ROUNDS(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .keyLoad  (keyLoad),
    .chave    (chave),
    .inValid  (inValid),
    .inReady  (inReady),
    .blocoIn  (blocoIn),
    .blocoOut (blocoOut),
    .outValid (outValid),
    .roundOut (roundOut)
  );

  always #5 clock = ~clock;

  localparam logic [127:0] KEY   = 128'h2B28AB097EAEF7CF15D2154F16A6883C;
  localparam logic [127:0] PT    = 128'h328831E0435A3137F6309807A88DA234;
  localparam logic [127:0] OUT0  = 128'h19A09AE93DF4C6F8E3E28D48BE2B2A08;
  localparam logic [127:0] KS1   = 128'hA088232AFA54A36CFE2C397617B13905;
  localparam logic [127:0] KS10  = 128'hD0C9E1B614EE3F63F9250C0CA889C8A6;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  // Round key r of a cipher key, both as row-major blocks (byte 0 leftmost).
  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0]  w [0:43];
    logic [31:0]  t;
    logic [7:0]   rc = 8'h01;
    logic [127:0] rk = '0;
    for (int i = 0; i < 4; i++)
      w[i] = {key[127-8*i -: 8], key[127-8*(4+i) -: 8], key[127-8*(8+i) -: 8], key[127-8*(12+i) -: 8]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        rk[127-8*(4*row+c) -: 8] = w[4*r+c][31-8*row -: 8];
    return rk;
  endfunction

  bit           m_live = 1'b0;
  bit           m_have_key;
  int           m_round;
  int           m_busy;
  logic [127:0] m_key;
  logic [127:0] m_out;
  logic [3:0]   m_round_out;
  bit           m_valid;

  always @(posedge clock) begin
    if (reset) begin
      m_live = 1'b1; m_have_key = 1'b0; m_round = 0; m_busy = 0;
      m_key = '0; m_out = '0; m_round_out = '0; m_valid = 1'b0;
    end else if (m_live) begin
      if (keyLoad) begin
        m_key = chave; m_have_key = 1'b1; m_round = 0; m_busy = 0; m_valid = 1'b0;
      end else if (inValid && m_have_key && m_busy == 0) begin
        m_out       = blocoIn ^ round_key(m_key, m_round);
        m_round_out = 4'(m_round);
        m_valid     = 1'b1;
        if (m_round < 10) begin m_busy = 4; m_round++; end
        else              begin m_busy = 1; m_round = 0; end
      end else begin
        m_valid = 1'b0;
        if (m_busy > 0) m_busy--;
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clock) begin
    if (m_live) begin
      check("inReady",  {127'b0, inReady},  {127'b0, (m_have_key && m_busy == 0)});
      check("outValid", {127'b0, outValid}, {127'b0, m_valid});
      check("roundOut", {124'b0, roundOut}, {124'b0, m_round_out});
      check("blocoOut", blocoOut, m_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!inReady && n < 32) begin step(); n++; end
    if (!inReady) check("ready_timeout", 128'(inReady), 128'd1);
  endtask

  task automatic accept(input logic [127:0] blk);
    wait_ready();
    blocoIn = blk;
    inValid = 1'b1;
    step();
    inValid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] key);
    chave   = key;
    keyLoad = 1'b1;
    step();
    keyLoad = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key2;
    int           cnt;

    reset = 1'b1; keyLoad = 1'b0; inValid = 1'b0; chave = '0; blocoIn = '0;
    init_sbox();
    step(); step();

    // Reset state.
    check("rst_inReady",  128'(inReady),  128'd0);
    check("rst_outValid", 128'(outValid), 128'd0);
    check("rst_blocoOut", blocoOut, 128'd0);
    reset = 1'b0;
    step();

    // Pin the model itself.
    check("model_sbox00", 128'(sb[8'h00]), 128'h63);
    check("model_sbox53", 128'(sb[8'h53]), 128'hED);
    check("model_ks1",  round_key(KEY, 1),  KS1);
    check("model_ks10", round_key(KEY, 10), KS10);

    // 1: round 0 against the known plaintext.
    load_key(KEY);
    accept(PT);
    check("t1_outValid", 128'(outValid), 128'd1);
    check("t1_roundOut", 128'(roundOut), 128'd0);
    check("t1_blocoOut", blocoOut, OUT0);

    // 2: inReady low for exactly 4 cycles, then round key 1.
    cnt = 0;
    while (!inReady && cnt < 20) begin cnt++; step(); end
    check("t2_busy_cycles", 128'(cnt), 128'd4);
    accept('0);
    check("t2_roundOut", 128'(roundOut), 128'd1);
    check("t2_blocoOut", blocoOut, KS1);

    // 3: run through round 10, wrap back to round 0.
    for (int r = 2; r <= 10; r++) accept('0);
    check("t3_roundOut10", 128'(roundOut), 128'd10);
    check("t3_blocoOut10", blocoOut, KS10);
    check("t3_wrap_busy", 128'(inReady), 128'd0);
    step();
    check("t3_wrap_ready", 128'(inReady), 128'd1);
    accept('0);
    check("t3_roundOut0", 128'(roundOut), 128'd0);
    check("t3_blocoOut0", blocoOut, KEY);

    // 4: keyLoad beats a simultaneous inValid.
    wait_ready();
    key2    = {$urandom, $urandom, $urandom, $urandom};
    chave   = key2;
    keyLoad = 1'b1;
    inValid = 1'b1;
    blocoIn = {$urandom, $urandom, $urandom, $urandom};
    step();
    keyLoad = 1'b0; inValid = 1'b0;
    check("t4_no_outValid", 128'(outValid), 128'd0);
    accept('0);
    check("t4_roundOut", 128'(roundOut), 128'd0);
    check("t4_blocoOut", blocoOut, key2);

    // 5: reset during expansion word 2, then ignored inputs in NOKEY.
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_blocoOut", blocoOut, 128'd0);
    check("t5_roundOut", 128'(roundOut), 128'd0);
    check("t5_inReady",  128'(inReady), 128'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      inValid = 1'(i % 2 == 0);
      blocoIn = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (outValid || inReady) cnt++;
    end
    inValid = 1'b0;
    check("t5_nokey_quiet", 128'(cnt), 128'd0);

    // 6: inValid held high: one accept every 5 cycles.
    load_key(KEY);
    inValid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      blocoIn = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (outValid) cnt++;
    end
    inValid = 1'b0;
    check("t6_accepts", 128'(cnt), 128'd5);

    // Randomized traffic with occasional key loads and resets.
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      keyLoad = ($urandom_range(0, 39) == 0);
      chave   = {$urandom, $urandom, $urandom, $urandom};
      inValid = ($urandom_range(0, 1) == 1);
      blocoIn = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    reset = 1'b0; keyLoad = 1'b0; inValid = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
